// File: rtl/r4_divider_64_if.sv
// r4_divider_64_if: start/operand handshake and registered result bundle for the radix-4 divider
interface r4_divider_64_if #(parameter int N = 64);
  logic         start;
  logic [N-1:0] dvd;
  logic [N-1:0] dvs;
  logic         busy;
  logic         done;
  logic [N-1:0] quo;
  logic [N-1:0] rem;
  logic         dbz;
  modport master(output start, dvd, dvs, input busy, done, quo, rem, dbz);
  modport slave(input start, dvd, dvs, output busy, done, quo, rem, dbz);
endinterface

// File: rtl/r4_divider_64.sv
// r4_divider_64: signed N-bit radix-4 restoring divider, 2 quotient bits per cycle
module r4_divider_64 #(parameter int N = 64) (
  input logic clk,
  input logic reset,
  r4_divider_64_if.slave bus
);
  localparam int CW = $clog2(N / 2);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_d;
  logic armed, zero, neg_q, neg_r, accept, b1, b2;
  logic [CW-1:0] cnt;
  logic [N:0] pr, s1, r1, s2, r2;
  logic [N-1:0] dm, dq, dvd_r;
  always_comb begin
    accept = (state == IDLE || state == DONE) && bus.start && armed;
    // pr[N] never sets in practice; folding it in keeps the step exact for any shifted value
    s1 = {pr[N-1:0], dq[N-1]};
    b1 = pr[N] | (s1 >= {1'b0, dm});
    r1 = b1 ? s1 - {1'b0, dm} : s1;
    s2 = {r1[N-1:0], dq[N-2]};
    b2 = r1[N] | (s2 >= {1'b0, dm});
    r2 = b2 ? s2 - {1'b0, dm} : s2;
    bus.busy = state == RUN || state == FIX;
    bus.done = state == DONE;
    state_d = state;
    case (state)
      IDLE, DONE: state_d = accept ? (bus.dvs == '0 ? FIX : RUN) : IDLE;
      RUN:        state_d = cnt == CW'(N / 2 - 1) ? FIX : RUN;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      armed   <= 1'b0;
      cnt     <= '0;
      pr      <= '0;
      dm      <= '0;
      dq      <= '0;
      dvd_r   <= '0;
      zero    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      bus.quo <= '0;
      bus.rem <= '0;
      bus.dbz <= 1'b0;
    end else begin
      state <= state_d;
      armed <= 1'b1;
      if (accept) begin
        dvd_r <= bus.dvd;
        dm    <= bus.dvs[N-1] ? -bus.dvs : bus.dvs;
        dq    <= bus.dvd[N-1] ? -bus.dvd : bus.dvd;
        neg_q <= bus.dvd[N-1] ^ bus.dvs[N-1];
        neg_r <= bus.dvd[N-1];
        zero  <= bus.dvs == '0;
        pr    <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        pr  <= r2;
        dq  <= {dq[N-3:0], b1, b2};
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        bus.quo <= zero ? '1 : neg_q ? -dq : dq;
        bus.rem <= zero ? dvd_r : neg_r ? -pr[N-1:0] : pr[N-1:0];
        bus.dbz <= zero;
      end
    end
  end
endmodule

// File: doc/r4_divider_64.md
R4_DIVIDER_64 -- requirements
Module: r4_divider_64

Interface
REQ-001 SHALL have parameter N, default 64, operand width in bits; N even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only when busy=0.
REQ-005 SHALL have port dvd  input  N  signed two's-complement dividend; sampled with start.
REQ-006 SHALL have port dvs  input  N  signed two's-complement divisor; sampled with start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; quo, rem and dbz valid in that cycle.
REQ-009 SHALL have port quo  output  N  signed quotient, registered, held until the next done.
REQ-010 SHALL have port rem  output  N  signed remainder, registered, held until the next done.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag, updated with done, held until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, register dvd and dvs, load their unsigned magnitudes and result signs, and enter RUN; otherwise IDLE and DONE go to IDLE.
REQ-014 SHALL keep busy=1 in RUN and FIX, and busy=0 in IDLE and DONE.
REQ-015 SHALL ignore start while busy=1, without changing operands or results.
REQ-016 SHALL, in RUN, retire 2 quotient bits per cycle by radix-4 restoring division: two cascaded shift, conditional-subtract steps on an (N+1)-bit partial remainder, MSB first.
REQ-017 SHALL stay in RUN for exactly N/2 cycles, using an iteration counter of ceil(log2(N/2)) bits that advances RUN -> FIX at terminal count.
REQ-018 SHALL, in FIX, negate the quotient magnitude if the operand signs differ, and negate the remainder magnitude if the dividend is negative, then enter DONE.
REQ-019 SHALL register quo, rem and dbz on the FIX -> DONE transition, and assert done=1 for the single DONE cycle.
REQ-020 SHALL have latency: done=1 exactly N/2+2 cycles after the edge that sampled start (34 cycles at N=64).
REQ-021 SHALL truncate the quotient toward zero and give the remainder the sign of the dividend, with dvd = quo*dvs + rem and |rem| < |dvs|.
REQ-022 SHALL treat magnitudes as unsigned N-bit, so the most-negative dividend has magnitude 2^(N-1) without overflow.
REQ-023 SHALL produce quo = most-negative value and rem = 0 for most-negative / -1, via two's-complement wrap, with no flag.
REQ-024 SHALL, on divisor = 0, skip RUN by going IDLE -> FIX -> DONE, with done at 2 cycles after the start edge, dbz=1, quo = all ones, rem = dvd.
REQ-025 SHALL clear dbz on any completed division with a nonzero divisor.
REQ-026 SHALL accept a start in the DONE cycle, giving back-to-back operations with no idle gap.

Reset
REQ-027 SHALL, with reset=1 at a rising edge, enter IDLE and clear busy, done, quo, rem, dbz, the iteration counter and the partial remainder to 0.
REQ-028 SHALL, on reset during RUN or FIX, abort the operation with no done pulse; reset takes priority over start in the same cycle.
REQ-029 SHALL ignore start during reset and in the first cycle after reset.

Verification
REQ-030 SHALL cover: start, dvd=100, dvs=7 -> done at cycle 34, quo=14, rem=2, dbz=0.
REQ-031 SHALL cover sign rules: -100/7 -> quo=-14, rem=-2; 100/-7 -> quo=-14, rem=2; -100/-7 -> quo=14, rem=-2.
REQ-032 SHALL cover: dvd=5, dvs=0 -> done at cycle 2, dbz=1, quo=0xFFFF_FFFF_FFFF_FFFF, rem=5; a following 9/3 -> quo=3, rem=0, dbz=0.
REQ-033 SHALL cover: dvd=0x8000_0000_0000_0000, dvs=-1 -> quo=0x8000_0000_0000_0000, rem=0, dbz=0.
REQ-034 SHALL cover: start pulsed at cycles 5 and 20 of an operation -> ignored, single done, operands of the first start used.
REQ-035 SHALL cover: reset asserted in RUN cycle 10 -> busy=0 next cycle, outputs 0, no done; a new 100/7 then completes normally.
